// File: rtl/arith_pkg.sv
// Shared types and sizing helpers for the sequential arithmetic units
// (multiplier and divider family).
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WORK = 2'd1,
    DONE = 2'd2
  } fsm_state_e;

  // Counter width able to hold LEN-1; never narrower than one bit.
  function automatic int cntWidth(input int len);
    return (len <= 2) ? 1 : $clog2(len);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {R,Q} left, trial-subtract the
// divisor, and keep the difference only if it did not borrow.
module div_step #(
  parameter int LEN = 32
) (
  input  logic [LEN:0]   rem_i,
  input  logic [LEN-1:0] quo_i,
  input  logic [LEN-1:0] divisor_i,
  output logic [LEN:0]   rem_o,
  output logic [LEN-1:0] quo_o
);

  logic [LEN+1:0] shifted;
  logic [LEN+1:0] trial;

  // One guard bit above R so the borrow of the subtraction is the sign bit.
  always_comb begin
    shifted = {rem_i, quo_i[LEN-1]};
    trial   = shifted - {2'b00, divisor_i};
    if (!trial[LEN+1]) begin
      rem_o = trial[LEN:0];
      quo_o = {quo_i[LEN-2:0], 1'b1};
    end else begin
      rem_o = shifted[LEN:0];
      quo_o = {quo_i[LEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock, with a
// start/finish handshake and a divide-by-zero flag.
module seq_divider
  import arith_pkg::*;
#(
  parameter int LEN = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [LEN-1:0] dividend,
  input  logic [LEN-1:0] divisor,
  input  logic           start,
  output logic [LEN-1:0] quotient,
  output logic [LEN-1:0] remainder,
  output logic           div_by_zero,
  output logic           busy,
  output logic           finish
);

  localparam int CW = cntWidth(LEN);

  fsm_state_e     state_q, state_d;
  logic [LEN-1:0] quo_q, quo_d;
  logic [LEN-1:0] divisor_q, divisor_d;
  logic [LEN:0]   rem_q, rem_d;
  logic [CW-1:0]  workCnt_q, workCnt_d;
  logic           dbz_q, dbz_d;
  logic [LEN:0]   stepRem;
  logic [LEN-1:0] stepQuo;

  div_step #(.LEN(LEN)) u_step (
    .rem_i    (rem_q),
    .quo_i    (quo_q),
    .divisor_i(divisor_q),
    .rem_o    (stepRem),
    .quo_o    (stepQuo)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      quo_q     <= '0;
      divisor_q <= '0;
      rem_q     <= '0;
      workCnt_q <= '0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      quo_q     <= quo_d;
      divisor_q <= divisor_d;
      rem_q     <= rem_d;
      workCnt_q <= workCnt_d;
      dbz_q     <= dbz_d;
    end
  end

  // A zero divisor skips WORK entirely; DONE waits for start to drop so a
  // level-held start produces exactly one operation.
  always_comb begin
    state_d   = state_q;
    quo_d     = quo_q;
    divisor_d = divisor_q;
    rem_d     = rem_q;
    workCnt_d = workCnt_q;
    dbz_d     = dbz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            quo_d   = '1;
            rem_d   = {1'b0, dividend};
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            divisor_d = divisor;
            quo_d     = dividend;
            rem_d     = '0;
            workCnt_d = CW'(LEN - 1);
            dbz_d     = 1'b0;
            state_d   = WORK;
          end
        end
      end
      WORK: begin
        rem_d = stepRem;
        quo_d = stepQuo;
        if (workCnt_q == '0) begin
          state_d = DONE;
        end else begin
          workCnt_d = workCnt_q - 1'b1;
        end
      end
      DONE: begin
        if (!start) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign quotient    = quo_q;
  assign remainder   = rem_q[LEN-1:0];
  assign div_by_zero = dbz_q;
  assign busy        = (state_q == WORK);
  assign finish      = (state_q == DONE);

endmodule

// File: tb/tb_seq_divider.sv
// Directed and random checks of seq_divider at LEN=8, 16 and 32 using a
// scoreboard of expected quotient/remainder/flag per started operation.
module tb_seq_divider;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [7:0]  d8A, d8B, d8Q, d8R;
  logic        d8Start, d8Dbz, d8Busy, d8Fin;
  logic [15:0] d16A, d16B, d16Q, d16R;
  logic        d16Start, d16Dbz, d16Busy, d16Fin;
  logic [31:0] d32A, d32B, d32Q, d32R;
  logic        d32Start, d32Dbz, d32Busy, d32Fin;

  seq_divider #(.LEN(8)) dut8 (
    .clk(clk), .rst(rst), .dividend(d8A), .divisor(d8B), .start(d8Start),
    .quotient(d8Q), .remainder(d8R), .div_by_zero(d8Dbz), .busy(d8Busy), .finish(d8Fin)
  );
  seq_divider #(.LEN(16)) dut16 (
    .clk(clk), .rst(rst), .dividend(d16A), .divisor(d16B), .start(d16Start),
    .quotient(d16Q), .remainder(d16R), .div_by_zero(d16Dbz), .busy(d16Busy), .finish(d16Fin)
  );
  seq_divider #(.LEN(32)) dut32 (
    .clk(clk), .rst(rst), .dividend(d32A), .divisor(d32B), .start(d32Start),
    .quotient(d32Q), .remainder(d32R), .div_by_zero(d32Dbz), .busy(d32Busy), .finish(d32Fin)
  );

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
  } exp_t;

  exp_t sb[$];
  int checksTotal  = 0;
  int checksPassed = 0;
  int checksFailed = 0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checksTotal++;
    assert (obs === expv) begin
      checksPassed++;
    end else begin
      checksFailed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] widthMask(input int sel);
    return (sel == 32) ? 32'hFFFF_FFFF : ((32'd1 << sel) - 32'd1);
  endfunction

  task automatic drive(input int sel, input logic [31:0] a, input logic [31:0] b, input logic s);
    case (sel)
      8:       begin d8A  = a[7:0];  d8B  = b[7:0];  d8Start  = s; end
      16:      begin d16A = a[15:0]; d16B = b[15:0]; d16Start = s; end
      default: begin d32A = a;       d32B = b;       d32Start = s; end
    endcase
  endtask

  task automatic sample(input int sel, output logic [31:0] q, output logic [31:0] r,
                        output logic dbz, output logic bsy, output logic fin);
    case (sel)
      8:       begin q = {24'd0, d8Q};  r = {24'd0, d8R};  dbz = d8Dbz;  bsy = d8Busy;  fin = d8Fin;  end
      16:      begin q = {16'd0, d16Q}; r = {16'd0, d16R}; dbz = d16Dbz; bsy = d16Busy; fin = d16Fin; end
      default: begin q = d32Q;          r = d32R;          dbz = d32Dbz; bsy = d32Busy; fin = d32Fin; end
    endcase
  endtask

  // Drives one start edge and records the reference result; start stays
  // asserted afterwards only when hold is set.
  task automatic applyStimulus(input int sel, input logic [31:0] a, input logic [31:0] b, input logic hold);
    exp_t e;
    logic [31:0] m;
    m = widthMask(sel);
    a = a & m;
    b = b & m;
    if (b == 32'd0) e = '{q: m, r: a, dbz: 1'b1};
    else            e = '{q: a / b, r: a % b, dbz: 1'b0};
    sb.push_back(e);
    drive(sel, a, b, 1'b1);
    tick();
    drive(sel, a, b, hold);
  endtask

  // Counts edges after the start edge until finish, and busy samples seen.
  task automatic waitDone(input int sel, input int budget, output int cycles, output int busyCnt);
    logic [31:0] q, r;
    logic dbz, bsy, fin;
    bit done;
    cycles  = 0;
    busyCnt = 0;
    done    = 1'b0;
    while (!done) begin
      sample(sel, q, r, dbz, bsy, fin);
      if (bsy) busyCnt++;
      if (fin) begin
        done = 1'b1;
      end else if (cycles >= budget) begin
        checkOutput("finishTimeout", {63'd0, fin}, 64'd1);
        done = 1'b1;
      end else begin
        tick();
        cycles++;
      end
    end
  endtask

  task automatic checkResult(input int sel, input string tag);
    exp_t e;
    logic [31:0] q, r;
    logic dbz, bsy, fin;
    if (sb.size() == 0) begin
      checkOutput({tag, ".scoreboardEmpty"}, 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      sample(sel, q, r, dbz, bsy, fin);
      checkOutput({tag, ".quotient"},  {32'd0, q}, {32'd0, e.q});
      checkOutput({tag, ".remainder"}, {32'd0, r}, {32'd0, e.r});
      checkOutput({tag, ".divByZero"}, {63'd0, dbz}, {63'd0, e.dbz});
    end
  endtask

  initial begin
    int cyc, bc;
    logic [31:0] q, r, a, b;
    logic dbz, bsy, fin;
    exp_t dropped;

    rst = 1'b0;
    drive(8, 0, 0, 0);
    drive(16, 0, 0, 0);
    drive(32, 0, 0, 0);
    tick();
    tick();
    sample(8, q, r, dbz, bsy, fin);
    checkOutput("reset.quotient",  {32'd0, q}, 64'd0);
    checkOutput("reset.remainder", {32'd0, r}, 64'd0);
    checkOutput("reset.flags", {61'd0, dbz, bsy, fin}, 64'd0);
    rst = 1'b1;
    tick();

    $display("[TB] basic 100/7 at LEN=8");
    applyStimulus(8, 100, 7, 1'b0);
    waitDone(8, 20, cyc, bc);
    checkOutput("t1.latency", cyc, 64'd8);
    checkOutput("t1.busyCycles", bc, 64'd8);
    checkResult(8, "t1");
    tick();
    sample(8, q, r, dbz, bsy, fin);
    checkOutput("t1.finishDrops", {63'd0, fin}, 64'd0);
    checkOutput("t1.quotientHeld", {32'd0, q}, 64'd14);

    $display("[TB] divide by zero 5/0 at LEN=8");
    applyStimulus(8, 5, 0, 1'b0);
    waitDone(8, 5, cyc, bc);
    checkOutput("t2.latency", cyc, 64'd0);
    checkOutput("t2.busyCycles", bc, 64'd0);
    checkResult(8, "t2");
    tick();

    $display("[TB] extremes at LEN=32");
    applyStimulus(32, 32'hFFFF_FFFF, 32'd1, 1'b0);
    waitDone(32, 40, cyc, bc);
    checkOutput("t3a.latency", cyc, 64'd32);
    checkResult(32, "t3a");
    tick();
    applyStimulus(32, 32'd3, 32'hFFFF_FFFF, 1'b0);
    waitDone(32, 40, cyc, bc);
    checkResult(32, "t3b");
    tick();

    $display("[TB] held start with operands changed during WORK");
    applyStimulus(8, 13, 4, 1'b1);
    drive(8, 200, 3, 1'b1);
    waitDone(8, 20, cyc, bc);
    checkResult(8, "t4");
    repeat (3) tick();
    sample(8, q, r, dbz, bsy, fin);
    checkOutput("t4.staysDone", {62'd0, bsy, fin}, 64'd1);
    checkOutput("t4.noRetrigger", {32'd0, q}, 64'd3);
    drive(8, 200, 3, 1'b0);
    tick();
    sample(8, q, r, dbz, bsy, fin);
    checkOutput("t4.idleFinish", {63'd0, fin}, 64'd0);
    checkOutput("t4.retained", {q, r}, {32'd3, 32'd1});

    $display("[TB] reset during WORK");
    applyStimulus(8, 200, 9, 1'b0);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    sample(8, q, r, dbz, bsy, fin);
    checkOutput("t5.resetValues", {q, r}, 64'd0);
    checkOutput("t5.resetFlags", {61'd0, dbz, bsy, fin}, 64'd0);
    dropped = sb.pop_front();
    tick();
    sample(8, q, r, dbz, bsy, fin);
    checkOutput("t5.staysIdle", {62'd0, bsy, fin}, 64'd0);
    applyStimulus(8, 200, 9, 1'b0);
    waitDone(8, 20, cyc, bc);
    checkResult(8, "t5");
    tick();

    $display("[TB] random regression at LEN=16");
    for (int i = 0; i < 1000; i++) begin
      a = $urandom_range(0, 65535);
      if (i % 4 == 0) b = $urandom_range((a >= 32'd65535) ? 65535 : int'(a) + 1, 65535);
      else            b = $urandom_range(1, 65535);
      applyStimulus(16, a, b, 1'b0);
      waitDone(16, 40, cyc, bc);
      sample(16, q, r, dbz, bsy, fin);
      checkResult(16, "rnd");
      checkOutput("rnd.identity", 64'(q) * 64'(b) + 64'(r), 64'(a));
      checkOutput("rnd.remLessThanDivisor", {63'd0, (r < b)}, 64'd1);
      tick();
    end

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
